// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a 16-bit little-endian word count followed by
// that many little-endian 32-bit words and writes them into IMEM from address 0.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 20000,
    parameter int ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err,
    output logic              load_err
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      MAX_N   = 17'(1) << ADDR_W;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_HDR_LO = 3'd0;
    localparam logic [2:0] L_HDR_HI = 3'd1;
    localparam logic [2:0] L_DATA   = 3'd2;
    localparam logic [2:0] L_DONE   = 3'd3;
    localparam logic [2:0] L_ERR    = 3'd4;

    // Synchronizer resets low so the idle level must actually be observed
    // before arming; this hides any byte already in flight when reset lifts.
    logic rx_meta_q, rx_sync_q, armed_q;

    logic [1:0]       rstate_q, rstate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [2:0]        lstate_q, lstate_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   word_q, word_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [15:0]       hdr_n;
    logic [15:0]       next_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            armed_q   <= armed_q | rx_sync_q;
        end
    end

    always_comb begin
        rstate_d     = rstate_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (rstate_q)
            R_IDLE: begin
                if (armed_q && !rx_sync_q) begin
                    rstate_d = R_START;
                    cnt_d    = '0;
                end
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    rstate_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) rstate_d = R_STOP;
                    else               bit_d    = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    rstate_d = R_IDLE;
                    if (rx_sync_q) byte_valid_d = 1'b1;
                    else           frame_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q     <= R_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rstate_q     <= rstate_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // shift_q holds the received byte while byte_valid_q is high
    assign hdr_n     = {shift_q, count_q[7:0]};
    assign next_word = 16'(word_q) + 16'd1;

    always_comb begin
        lstate_d = lstate_q;
        count_d  = count_q;
        word_d   = word_q;
        bidx_d   = bidx_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        case (lstate_q)
            L_HDR_LO: begin
                if (byte_valid_q) begin
                    count_d[7:0] = shift_q;
                    lstate_d     = L_HDR_HI;
                end
            end
            L_HDR_HI: begin
                if (byte_valid_q) begin
                    count_d[15:8] = shift_q;
                    word_d        = '0;
                    bidx_d        = '0;
                    if (hdr_n == 16'd0)                lstate_d = L_DONE;
                    else if ({1'b0, hdr_n} > MAX_N)    lstate_d = L_ERR;
                    else                               lstate_d = L_DATA;
                end
            end
            L_DATA: begin
                if (we_q) begin
                    word_d = word_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (next_word == count_q) lstate_d = L_DONE;
                end
                if (byte_valid_q) begin
                    wdata_d[{bidx_q, 3'b000} +: 8] = shift_q;
                    bidx_d = bidx_q + 1'b1;
                    if (bidx_q == 2'd3) we_d = 1'b1;
                end
            end
            L_DONE:  lstate_d = L_DONE;
            L_ERR:   lstate_d = L_ERR;
            default: lstate_d = L_HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lstate_q <= L_HDR_LO;
            count_q  <= '0;
            word_q   <= '0;
            bidx_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            lstate_q <= lstate_d;
            count_q  <= count_d;
            word_q   <= word_d;
            bidx_q   <= bidx_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = word_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (lstate_q != L_DONE);
    assign load_done  = (lstate_q == L_DONE);
    assign load_err   = (lstate_q == L_ERR);
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader: a byte-stream model predicts IMEM
// writes into a queue that a forked monitor pops on every imem_we pulse.
module tb_imem_uart_loader;
    localparam int CPB = 16;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, load_done, frame_err, load_err;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .frame_err(frame_err), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; bit last; } wr_t;
    // kind: 0 good byte, 1 byte with low stop bit, 2 4-cycle glitch, 3 8-cycle glitch
    typedef struct { int kind; logic [7:0] b; } ev_t;

    wr_t  exp_q[$];
    ev_t  stream[$];
    int   checks   = 0;
    int   failures = 0;
    bit   e_done, e_err, e_ferr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"},    {31'd0, imem_we},   32'd0);
        chk({tag, "_addr"},  {21'd0, imem_addr}, 32'd0);
        chk({tag, "_wdata"}, imem_wdata,         32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold},  32'd1);
        chk({tag, "_done"},  {31'd0, load_done}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
        chk({tag, "_lerr"},  {31'd0, load_err},  32'd0);
    endtask

    task automatic add(input int kind, input logic [7:0] b);
        ev_t e;
        e.kind = kind;
        e.b    = b;
        stream.push_back(e);
    endtask

    // Reference: filter the good bytes, read the header, slice the rest into words.
    task automatic model(output bit done, output bit err, output bit ferr);
        logic [7:0] g[$];
        int n;
        wr_t w;
        done = 0; err = 0; ferr = 0;
        foreach (stream[i]) begin
            if (stream[i].kind == 0) g.push_back(stream[i].b);
            if (stream[i].kind == 1) ferr = 1;
        end
        if (g.size() < 2) return;
        n = int'({g[1], g[0]});
        if (n == 0) done = 1;
        else if (n > (1 << AW)) err = 1;
        else begin
            for (int i = 0; i < n; i++) begin
                if (2 + 4 * i + 3 < g.size()) begin
                    w.addr = AW'(i);
                    w.data = {g[2+4*i+3], g[2+4*i+2], g[2+4*i+1], g[2+4*i]};
                    w.last = (i == n - 1);
                    exp_q.push_back(w);
                end
            end
            done = (g.size() >= 2 + 4 * n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        @(posedge clk); rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        if (good) begin
            rx = 1'b1;
            repeat (CPB) @(posedge clk);
        end else begin
            // low only past the mid-bit sample so the receiver re-idles cleanly
            rx = 1'b0;
            repeat (10) @(posedge clk);
            rx = 1'b1;
            repeat (6) @(posedge clk);
        end
        repeat (16) @(posedge clk);
    endtask

    task automatic glitch(input int len);
        @(posedge clk); rx = 1'b0;
        repeat (len) @(posedge clk);
        rx = 1'b1;
        repeat (24) @(posedge clk);
    endtask

    task automatic play();
        foreach (stream[i]) begin
            case (stream[i].kind)
                0: send_byte(stream[i].b, 1'b1);
                1: send_byte(stream[i].b, 1'b0);
                2: glitch(4);
                default: glitch(8);
            endcase
        end
    endtask

    task automatic run_scn(input string nm);
        model(e_done, e_err, e_ferr);
        play();
        repeat (40) @(posedge clk);
        #1;
        chk({nm, "_pending"}, exp_q.size(),        32'd0);
        chk({nm, "_done"},    {31'd0, load_done},  {31'd0, e_done});
        chk({nm, "_hold"},    {31'd0, cpu_hold},   {31'd0, !e_done});
        chk({nm, "_lerr"},    {31'd0, load_err},   {31'd0, e_err});
        chk({nm, "_ferr"},    {31'd0, frame_err},  {31'd0, e_ferr});
        exp_q.delete();
        stream.delete();
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk_reset(tag);
        rst = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        bit pend_done;
        bit prev_we;
        int n;
        logic [7:0] b;
        rst = 1'b0;
        rx  = 1'b1;
        pend_done = 0;
        prev_we   = 0;

        fork
            forever begin
                @(negedge clk);
                if (pend_done) begin
                    chk("done_after_last", {30'd0, load_done, cpu_hold}, 32'd2);
                    pend_done = 0;
                end
                if (imem_we === 1'b1) begin
                    chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write addr=%h data=%h required=none", imem_addr, imem_wdata);
                    end else begin
                        wr_t w;
                        w = exp_q.pop_front();
                        chk("wr_addr", {21'd0, imem_addr}, {21'd0, w.addr});
                        chk("wr_data", imem_wdata, w.data);
                        if (w.last) pend_done = 1;
                    end
                end
                prev_we = imem_we;
            end
        join_none

        reset_dut("rst0");

        // directed two-word image
        add(0, 8'h02); add(0, 8'h00);
        add(0, 8'h78); add(0, 8'h56); add(0, 8'h34); add(0, 8'h12);
        add(0, 8'hEF); add(0, 8'hBE); add(0, 8'hAD); add(0, 8'hDE);
        run_scn("two_words");

        reset_dut("rst1");
        add(0, 8'h00); add(0, 8'h00); add(0, 8'h11); add(0, 8'h22);
        run_scn("empty_image");

        reset_dut("rst2");
        add(0, 8'h01); add(0, 8'h08);
        for (int i = 0; i < 20; i++) add(0, 8'($urandom));
        run_scn("too_long");

        // largest legal count: accepted, loading still in progress
        reset_dut("rst3");
        add(0, 8'h00); add(0, 8'h08);
        for (int i = 0; i < 8; i++) add(0, 8'($urandom));
        run_scn("max_count");

        // frame errors and glitches sprinkled between data bytes
        for (int t = 0; t < 4; t++) begin
            reset_dut("rstr");
            n = $urandom_range(1, 4);
            add(0, 8'(n)); add(0, 8'h00);
            for (int i = 0; i < 4 * n; i++) begin
                case ($urandom_range(0, 7))
                    0: add(1, 8'($urandom));
                    1: add(2, 8'h00);
                    2: add(3, 8'h00);
                    default: ;
                endcase
                add(0, 8'($urandom));
            end
            add(0, 8'($urandom)); add(0, 8'($urandom));
            run_scn("random_load");
        end

        // reset mid-load, released while a byte is already on the wire
        reset_dut("rst4");
        add(0, 8'h02); add(0, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 8'($urandom));
        model(e_done, e_err, e_ferr);
        play();
        stream.delete();
        @(posedge clk); rx = 1'b0;
        repeat (40) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_reset("mid_rst");
        chk("mid_rst_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (100) @(posedge clk);
        rx = 1'b1;
        repeat (32) @(posedge clk);
        add(0, 8'h02); add(0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            add(0, b);
        end
        run_scn("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 20000, the number of clk cycles per UART bit (minimum 4).
REQ-002 Parameter ADDR_W, default 11, the IMEM word-address width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port rx, input, 1: UART serial in (8N1, LSB first, idle high); asynchronous to clk.
REQ-006 Port imem_we, output, 1: IMEM write strobe, one-cycle pulse.
REQ-007 Port imem_addr, output, ADDR_W: IMEM word address.
REQ-008 Port imem_wdata, output, 32: IMEM write data.
REQ-009 Port cpu_hold, output, 1: holds the CPU in reset while high.
REQ-010 Port load_done, output, 1: image fully written.
REQ-011 Port frame_err, output, 1: sticky flag; a stop bit was sampled low.
REQ-012 Port load_err, output, 1: sticky flag; the header word count exceeded 2^ADDR_W.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver states SHALL be R_IDLE, R_START, R_DATA and R_STOP.
REQ-015 In R_IDLE, a synchronized rx low SHALL enter R_START.
REQ-016 R_START SHALL wait CLKS_PER_BIT/2 cycles, then go to R_DATA if rx is low, else return to R_IDLE (false start, no byte).
REQ-017 R_DATA SHALL sample 8 bits at CLKS_PER_BIT spacing, LSB first.
REQ-018 R_STOP SHALL sample rx after CLKS_PER_BIT cycles.
REQ-019 A high stop bit SHALL raise an internal byte_valid for 1 cycle.
REQ-020 A low stop bit SHALL discard the byte, set frame_err, and return to R_IDLE with no byte_valid.
REQ-021 Loader states SHALL be L_HDR_LO, L_HDR_HI, L_DATA, L_DONE and L_ERR.
REQ-022 The loader SHALL act on byte_valid only.
REQ-023 L_HDR_LO SHALL latch the count low byte, then go to L_HDR_HI.
REQ-024 L_HDR_HI SHALL latch the count high byte, forming N (16-bit, little-endian), then branch:
- N=0 -> L_DONE;
- N>2^ADDR_W -> L_ERR;
- otherwise -> L_DATA with word index 0 and byte index 0.
REQ-025 L_DATA SHALL assemble each word little-endian: byte 0 -> [7:0], byte 3 -> [31:24].
REQ-026 On the 4th byte_valid of a word, imem_we SHALL be 1 on the next cycle, with imem_addr = word index and imem_wdata = assembled word, both stable during that cycle.
REQ-027 The word index SHALL increment the cycle after each imem_we pulse and SHALL NOT wrap within a legal load.
REQ-028 After the N-th write, the loader SHALL enter L_DONE on the following cycle.
REQ-029 In L_DONE, load_done SHALL be 1 and cpu_hold 0; further rx bytes SHALL be received but ignored (no imem_we).
REQ-030 In L_ERR, cpu_hold SHALL stay 1 and load_done 0 until reset; bytes SHALL be ignored.
REQ-031 A frame error during L_DATA SHALL NOT advance the byte index; the loader continues with the next good byte.
REQ-032 imem_we SHALL be 0 outside the single write cycle.
REQ-033 Latency from the stop-bit sample of byte 3 to imem_we SHALL be exactly 2 cycles.

Reset
REQ-034 rst low SHALL force, asynchronously and at any time including mid-byte or mid-word:
- imem_we=0, imem_addr=0, imem_wdata=0;
- cpu_hold=1, load_done=0, frame_err=0, load_err=0;
- both FSMs to R_IDLE / L_HDR_LO; all counters cleared.
REQ-035 After rst rises, a partial byte already in progress on rx SHALL be ignored until rx has been seen high (idle) at least once.

Verification (CLKS_PER_BIT=16)
REQ-036 Send bytes 02 00 78 56 34 12 EF BE AD DE -> imem_we pulses twice: (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF); load_done=1 and cpu_hold=0 the cycle after the 2nd pulse.
REQ-037 Send header 00 00 -> load_done=1 after byte 2, no imem_we pulses.
REQ-038 Send header 01 08 (N=2049) -> load_err=1, cpu_hold stays 1, no imem_we even after 8196 more bytes.
REQ-039 Send a byte with its stop bit low between data bytes -> frame_err=1, that byte is dropped, and the word assembles correctly from the next 4 good bytes.
REQ-040 Glitch rx low for 4 cycles -> no byte_valid and state unchanged; send an 8-cycle low glitch the same way -> no byte_valid.
REQ-041 Assert rst after 6 data bytes of an N=2 load -> all outputs return to reset values; a fresh full load then writes from addr 0.
